eth_stats_collector_mc: RTL and testbench



---
 rtl/eth_stats_mc_pkg.sv | 28 ++
 rtl/eth_stats_collector_mc_if.sv | 48 ++++
 rtl/eth_stats_channel.sv | 87 ++++++++
 rtl/eth_stats_collector_mc.sv | 142 ++++++++++++++
 tb/tb_eth_stats_collector_mc.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_stats_mc_pkg.sv
// rtl/eth_stats_mc_pkg.sv - shared constants and helpers for the multi-channel stats collector
// Contents:
//   HDR_MAGIC      record header magic byte
//   CNT_*          counter slot indices inside one channel, NUM_CNT slots total
//   state_e        record sender states
//   rec_len(n, w)  record length in 32-bit words for n channels, w words per counter
package eth_stats_mc_pkg;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   localparam int CNT_TX_FRAMES = 0;
   localparam int CNT_TX_BYTES  = 1;
   localparam int CNT_RX_FRAMES = 2;
   localparam int CNT_RX_BYTES  = 3;
   localparam int CNT_RX_BAD    = 4;
   localparam int NUM_CNT       = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // header + two timestamp words + every counter of every channel
   function automatic int rec_len(input int n, input int w);
      return 3 + NUM_CNT * n * w;
   endfunction

endpackage

// File: rtl/eth_stats_collector_mc_if.sv
// rtl/eth_stats_collector_mc_if.sv - tap, control and record-stream bundle of the stats collector
// Signals:
//   current_time, time_running, enable, sample_period, sample_req, clear   control
//   tx_tvalid/tx_tready/tx_tlast/tx_tkeep    TX taps, channel i at bit/slice i
//   rx_tvalid/rx_tlast/rx_tuser/rx_tkeep     RX taps, channel i at bit/slice i
//   m_axis_tdata/tvalid/tlast/tready         record stream
//   busy, overflow_count                     status
// Modports: master = environment driving the taps, slave = the collector.
interface eth_stats_collector_mc_if #(
   parameter int N          = 4,
   parameter int BEAT_BYTES = 1
);
   logic [63:0]             current_time;
   logic                    time_running;
   logic                    enable;
   logic [31:0]             sample_period;
   logic                    sample_req;
   logic                    clear;
   logic [N-1:0]            tx_tvalid;
   logic [N-1:0]            tx_tready;
   logic [N-1:0]            tx_tlast;
   logic [N*BEAT_BYTES-1:0] tx_tkeep;
   logic [N-1:0]            rx_tvalid;
   logic [N-1:0]            rx_tlast;
   logic [N-1:0]            rx_tuser;
   logic [N*BEAT_BYTES-1:0] rx_tkeep;
   logic [31:0]             m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tlast;
   logic                    m_axis_tready;
   logic                    busy;
   logic [15:0]             overflow_count;

   modport master (
      output current_time, time_running, enable, sample_period, sample_req, clear,
             tx_tvalid, tx_tready, tx_tlast, tx_tkeep,
             rx_tvalid, rx_tlast, rx_tuser, rx_tkeep, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, overflow_count
   );

   modport slave (
      input  current_time, time_running, enable, sample_period, sample_req, clear,
             tx_tvalid, tx_tready, tx_tlast, tx_tkeep,
             rx_tvalid, rx_tlast, rx_tuser, rx_tkeep, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, overflow_count
   );

endinterface

// File: rtl/eth_stats_channel.sv
// rtl/eth_stats_channel.sv - live and shadow statistics counters for one channel
// Ports:
//   clk, rst                                clock, asynchronous active-high reset
//   cnt_en_i                                counting enabled this cycle
//   clear_i                                 zero live counters, discarding this cycle's increment
//   snap_i                                  accepted snapshot: live values move to the shadows
//   tx_beat_i, tx_last_i, tx_keep_i         TX beat qualifiers
//   rx_beat_i, rx_last_i, rx_bad_i, rx_keep_i  RX beat qualifiers
//   shadow_o                                frozen counters, counter slot c at slice c
module eth_stats_channel
   import eth_stats_mc_pkg::*;
#(
   parameter int C_COUNTER_WIDTH   = 64,
   parameter int C_BEAT_BYTES      = 1,
   parameter int C_CLEAR_ON_SAMPLE = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cnt_en_i,
   input  logic                                 clear_i,
   input  logic                                 snap_i,
   input  logic                                 tx_beat_i,
   input  logic                                 tx_last_i,
   input  logic [C_BEAT_BYTES-1:0]              tx_keep_i,
   input  logic                                 rx_beat_i,
   input  logic                                 rx_last_i,
   input  logic                                 rx_bad_i,
   input  logic [C_BEAT_BYTES-1:0]              rx_keep_i,
   output logic [NUM_CNT*C_COUNTER_WIDTH-1:0]   shadow_o
);

   localparam int CW = C_COUNTER_WIDTH;

   logic [CW-1:0] live_q   [NUM_CNT];
   logic [CW-1:0] live_d   [NUM_CNT];
   logic [CW-1:0] shadow_q [NUM_CNT];
   logic [CW-1:0] inc      [NUM_CNT];

   function automatic logic [CW-1:0] popcount(input logic [C_BEAT_BYTES-1:0] k);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < C_BEAT_BYTES; i++) n = n + CW'(k[i]);
      return n;
   endfunction

   always_comb begin
      for (int c = 0; c < NUM_CNT; c++) inc[c] = '0;
      if (cnt_en_i && tx_beat_i) begin
         inc[CNT_TX_BYTES]  = tx_last_i ? popcount(tx_keep_i) : CW'(C_BEAT_BYTES);
         inc[CNT_TX_FRAMES] = CW'(tx_last_i);
      end
      if (cnt_en_i && rx_beat_i) begin
         inc[CNT_RX_BYTES]  = rx_last_i ? popcount(rx_keep_i) : CW'(C_BEAT_BYTES);
         inc[CNT_RX_FRAMES] = CW'(rx_last_i);
         inc[CNT_RX_BAD]    = CW'(rx_last_i & rx_bad_i);
      end
      for (int c = 0; c < NUM_CNT; c++) begin
         if (clear_i) begin
            live_d[c] = '0;
         end else if (snap_i && (C_CLEAR_ON_SAMPLE != 0)) begin
            // the snapshot takes the pre-edge value, so this cycle's beat starts the new interval
            live_d[c] = inc[c];
         end else begin
            live_d[c] = live_q[c] + inc[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CNT; c++) begin
            live_q[c]   <= '0;
            shadow_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CNT; c++) begin
            live_q[c] <= live_d[c];
            if (snap_i) shadow_q[c] <= live_q[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CNT; c++) shadow_o[c*CW +: CW] = shadow_q[c];
   end

endmodule

// File: rtl/eth_stats_collector_mc.sv
// rtl/eth_stats_collector_mc.sv - multi-channel Ethernet statistics collector with record streaming
// Ports:
//   clk   sole clock
//   rst   asynchronous active-high reset
//   bus   slave side of eth_stats_collector_mc_if: taps and control in, record stream and status out
// Holds the period timer, the record sender FSM, the word mux, seq and the dropped-trigger count;
// per-channel counting lives in eth_stats_channel.
module eth_stats_collector_mc
   import eth_stats_mc_pkg::*;
#(
   parameter int C_NUM_CHANNELS    = 4,
   parameter int C_COUNTER_WIDTH   = 64,
   parameter int C_BEAT_BYTES      = 1,
   parameter int C_CLEAR_ON_SAMPLE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   eth_stats_collector_mc_if.slave   bus
);

   localparam int N  = C_NUM_CHANNELS;
   localparam int W  = C_COUNTER_WIDTH / 32;
   localparam int L  = rec_len(N, W);
   localparam int IW = $clog2(L);
   localparam int CB = NUM_CNT * C_COUNTER_WIDTH;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [15:0]     seq_q, seq_d;
   logic [15:0]     ovf_q, ovf_d;
   logic [31:0]     timer_q, timer_d;
   logic [63:0]     ts_q;
   logic            cnt_en, timer_ev, trigger, hs, snap;
   logic [N*CB-1:0] shadow_all;
   logic [31:0]     words [L];

   assign cnt_en  = bus.enable & bus.time_running;
   assign hs      = (state_q == ST_SEND) & bus.m_axis_tready;
   assign trigger = timer_ev | bus.sample_req;

   always_comb begin
      timer_d  = timer_q;
      timer_ev = 1'b0;
      if (bus.sample_period == 32'd0) begin
         timer_d = '0;
      end else if (cnt_en) begin
         // >= rather than == so a shortened period cannot strand the timer above it
         if (timer_q >= bus.sample_period - 32'd1) begin
            timer_ev = 1'b1;
            timer_d  = '0;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      ovf_d   = ovf_q;
      snap    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               snap    = 1'b1;
               state_d = ST_SEND;
               idx_d   = '0;
            end
         end
         ST_SEND: begin
            if (hs) begin
               if (idx_q == IW'(L - 1)) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  seq_d   = seq_q + 16'd1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            // any trigger while a record is in flight is lost, even on the final handshake
            if (trigger && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
         ovf_q   <= '0;
         timer_q <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         timer_q <= timer_d;
         if (snap) ts_q <= bus.current_time;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_ch
      eth_stats_channel #(
         .C_COUNTER_WIDTH   (C_COUNTER_WIDTH),
         .C_BEAT_BYTES      (C_BEAT_BYTES),
         .C_CLEAR_ON_SAMPLE (C_CLEAR_ON_SAMPLE)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .cnt_en_i  (cnt_en),
         .clear_i   (bus.clear),
         .snap_i    (snap),
         .tx_beat_i (bus.tx_tvalid[g] & bus.tx_tready[g]),
         .tx_last_i (bus.tx_tlast[g]),
         .tx_keep_i (bus.tx_tkeep[g*C_BEAT_BYTES +: C_BEAT_BYTES]),
         .rx_beat_i (bus.rx_tvalid[g]),
         .rx_last_i (bus.rx_tlast[g]),
         .rx_bad_i  (bus.rx_tuser[g]),
         .rx_keep_i (bus.rx_tkeep[g*C_BEAT_BYTES +: C_BEAT_BYTES]),
         .shadow_o  (shadow_all[g*CB +: CB])
      );
   end

   // shadow_all is already ordered channel, counter, low word first, so record words map linearly
   always_comb begin
      words[0] = {HDR_MAGIC, 8'(N), seq_q};
      words[1] = ts_q[31:0];
      words[2] = ts_q[63:32];
      for (int k = 0; k < NUM_CNT * N * W; k++) words[k+3] = shadow_all[k*32 +: 32];
   end

   assign bus.busy           = (state_q == ST_SEND);
   assign bus.m_axis_tvalid  = (state_q == ST_SEND);
   assign bus.m_axis_tdata   = (state_q == ST_SEND) ? words[idx_q] : 32'd0;
   assign bus.m_axis_tlast   = (state_q == ST_SEND) && (idx_q == IW'(L - 1));
   assign bus.overflow_count = ovf_q;

endmodule

// File: tb/tb_eth_stats_collector_mc.sv
// tb/tb_eth_stats_collector_mc.sv - scoreboard bench for eth_stats_collector_mc (plain and clear-on-sample)
module tb_eth_stats_collector_mc;
   import eth_stats_mc_pkg::*;

   localparam int N  = 2;
   localparam int CW = 64;
   localparam int W  = CW / 32;
   localparam int BB = 4;
   localparam int L  = rec_len(N, W);

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eth_stats_collector_mc_if #(.N(N), .BEAT_BYTES(BB)) ifa ();
   eth_stats_collector_mc_if #(.N(N), .BEAT_BYTES(BB)) ifb ();

   eth_stats_collector_mc #(.C_NUM_CHANNELS(N), .C_COUNTER_WIDTH(CW), .C_BEAT_BYTES(BB),
                            .C_CLEAR_ON_SAMPLE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   eth_stats_collector_mc #(.C_NUM_CHANNELS(N), .C_COUNTER_WIDTH(CW), .C_BEAT_BYTES(BB),
                            .C_CLEAR_ON_SAMPLE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   assign ifb.current_time  = ifa.current_time;
   assign ifb.time_running  = ifa.time_running;
   assign ifb.enable        = ifa.enable;
   assign ifb.sample_period = ifa.sample_period;
   assign ifb.sample_req    = ifa.sample_req;
   assign ifb.clear         = ifa.clear;
   assign ifb.tx_tvalid     = ifa.tx_tvalid;
   assign ifb.tx_tready     = ifa.tx_tready;
   assign ifb.tx_tlast      = ifa.tx_tlast;
   assign ifb.tx_tkeep      = ifa.tx_tkeep;
   assign ifb.rx_tvalid     = ifa.rx_tvalid;
   assign ifb.rx_tlast      = ifa.rx_tlast;
   assign ifb.rx_tuser      = ifa.rx_tuser;
   assign ifb.rx_tkeep      = ifa.rx_tkeep;
   assign ifb.m_axis_tready = ifa.m_axis_tready;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model: variant 0 accumulates, variant 1 restarts on every accepted snapshot
   logic [63:0] live [2][N][NUM_CNT];
   word_t       qa[$];
   word_t       qb[$];
   int          rem;
   logic [15:0] seq_m;
   logic [15:0] ovf_m;
   logic [31:0] tmr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm, input string why);
      checks++;
      failures++;
      $display("FAIL %s %s (t=%0t)", nm, why, $time);
   endtask

   function automatic void model_reset();
      for (int v = 0; v < 2; v++)
         for (int ch = 0; ch < N; ch++)
            for (int c = 0; c < NUM_CNT; c++) live[v][ch][c] = '0;
      rem = 0; seq_m = '0; ovf_m = '0; tmr = '0;
      qa.delete();
      qb.delete();
   endfunction

   // effect of the coming clock edge given the inputs currently driven
   function automatic void model_step();
      logic [63:0] inc [N][NUM_CNT];
      logic        en, tev, trig, accept;
      logic [31:0] rw [L];
      en  = ifa.enable & ifa.time_running;
      tev = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
         for (int c = 0; c < NUM_CNT; c++) inc[ch][c] = '0;
         if (en && ifa.tx_tvalid[ch] && ifa.tx_tready[ch]) begin
            inc[ch][CNT_TX_FRAMES] = 64'(ifa.tx_tlast[ch]);
            inc[ch][CNT_TX_BYTES]  = ifa.tx_tlast[ch] ? 64'($countones(ifa.tx_tkeep[ch*BB +: BB])) : 64'(BB);
         end
         if (en && ifa.rx_tvalid[ch]) begin
            inc[ch][CNT_RX_FRAMES] = 64'(ifa.rx_tlast[ch]);
            inc[ch][CNT_RX_BYTES]  = ifa.rx_tlast[ch] ? 64'($countones(ifa.rx_tkeep[ch*BB +: BB])) : 64'(BB);
            inc[ch][CNT_RX_BAD]    = 64'(ifa.rx_tlast[ch] & ifa.rx_tuser[ch]);
         end
      end
      if (ifa.sample_period == 0) tmr = 0;
      else if (en) begin
         if (tmr >= ifa.sample_period - 1) begin tev = 1'b1; tmr = 0; end
         else tmr = tmr + 1;
      end
      trig   = tev | ifa.sample_req;
      accept = trig && (rem == 0);
      if (trig && rem > 0 && ovf_m != 16'hFFFF) ovf_m = ovf_m + 1;
      if (accept) begin
         for (int v = 0; v < 2; v++) begin
            rw[0] = {8'hA5, 8'(N), seq_m};
            rw[1] = ifa.current_time[31:0];
            rw[2] = ifa.current_time[63:32];
            for (int ch = 0; ch < N; ch++)
               for (int c = 0; c < NUM_CNT; c++)
                  for (int w = 0; w < W; w++)
                     rw[3 + (ch*NUM_CNT + c)*W + w] = live[v][ch][c][w*32 +: 32];
            for (int k = 0; k < L; k++) begin
               if (v == 0) qa.push_back('{rw[k], k == L-1});
               else        qb.push_back('{rw[k], k == L-1});
            end
         end
         rem = L;
      end else if (rem > 0 && ifa.m_axis_tready) begin
         rem = rem - 1;
         if (rem == 0) seq_m = seq_m + 1;
      end
      for (int v = 0; v < 2; v++)
         for (int ch = 0; ch < N; ch++)
            for (int c = 0; c < NUM_CNT; c++) begin
               if (ifa.clear)              live[v][ch][c] = '0;
               else if (accept && v == 1)  live[v][ch][c] = inc[ch][c];
               else                        live[v][ch][c] = live[v][ch][c] + inc[ch][c];
            end
   endfunction

   task automatic step();
      chk("busy_a", ifa.busy, rem > 0);
      chk("busy_b", ifb.busy, rem > 0);
      chk("ovf_a", ifa.overflow_count, ovf_m);
      chk("ovf_b", ifb.overflow_count, ovf_m);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      ifa.sample_req = 1'b0;
      ifa.clear      = 1'b0;
      ifa.tx_tvalid  = '0;
      ifa.tx_tlast   = '0;
      ifa.rx_tvalid  = '0;
      ifa.rx_tlast   = '0;
      ifa.rx_tuser   = '0;
      ifa.current_time = {32'($urandom), 32'(cyc)};
   endtask

   task automatic drain();
      ifa.m_axis_tready = 1'b1;
      for (int i = 0; i < 2000 && rem > 0; i++) step();
      if (rem > 0) fail_now("drain", "record did not complete within 2000 cycles");
      step();
   endtask

   task automatic snapshot();
      ifa.sample_req = 1'b1;
      step();
      drain();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_tvalid_a", ifa.m_axis_tvalid, 0);
      chk("rst_tvalid_b", ifb.m_axis_tvalid, 0);
      chk("rst_tlast_a", ifa.m_axis_tlast, 0);
      chk("rst_busy_a", ifa.busy, 0);
      chk("rst_tdata_a", ifa.m_axis_tdata, 0);
      chk("rst_ovf_a", ifa.overflow_count, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // monitor: compares every presented word against the scoreboard, pops on handshake
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ifa.m_axis_tvalid) begin
               if (qa.size() == 0) fail_now("a_word", "valid word with no record expected");
               else begin
                  chk("a_tdata", ifa.m_axis_tdata, qa[0].data);
                  chk("a_tlast", ifa.m_axis_tlast, qa[0].last);
                  if (ifa.m_axis_tready) void'(qa.pop_front());
               end
            end
            if (ifb.m_axis_tvalid) begin
               if (qb.size() == 0) fail_now("b_word", "valid word with no record expected");
               else begin
                  chk("b_tdata", ifb.m_axis_tdata, qb[0].data);
                  chk("b_tlast", ifb.m_axis_tlast, qb[0].last);
                  if (ifb.m_axis_tready) void'(qb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ifa.current_time = '0; ifa.time_running = 1'b1; ifa.enable = 1'b1;
      ifa.sample_period = '0; ifa.sample_req = 1'b0; ifa.clear = 1'b0;
      ifa.tx_tvalid = '0; ifa.tx_tready = '1; ifa.tx_tlast = '0; ifa.tx_tkeep = '1;
      ifa.rx_tvalid = '0; ifa.rx_tlast = '0; ifa.rx_tuser = '0; ifa.rx_tkeep = '1;
      ifa.m_axis_tready = 1'b1;
      @(posedge clk); #1;
      do_reset();

      // ch0 TX 3-beat frame, last keep 0011 -> 10 bytes
      for (int b = 0; b < 3; b++) begin
         ifa.tx_tvalid[0] = 1'b1;
         ifa.tx_tlast[0]  = (b == 2);
         ifa.tx_tkeep[3:0] = (b == 2) ? 4'b0011 : 4'b1111;
         step();
      end
      ifa.tx_tkeep = '1;
      snapshot();

      // ch1 RX: two frames, second flagged bad
      for (int b = 0; b < 3; b++) begin
         ifa.rx_tvalid[1] = 1'b1;
         ifa.rx_tlast[1]  = (b != 0);
         ifa.rx_tuser[1]  = (b == 2);
         ifa.rx_tkeep[7:4] = (b == 2) ? 4'b0001 : 4'b1111;
         step();
      end
      ifa.rx_tkeep = '1;
      snapshot();

      // TX last beat in the trigger cycle lands in the following snapshot
      ifa.tx_tvalid[0] = 1'b1;
      ifa.tx_tlast[0]  = 1'b1;
      ifa.sample_req   = 1'b1;
      step();
      drain();
      snapshot();

      // clear beats a simultaneous RX last beat
      ifa.rx_tvalid[1] = 1'b1;
      ifa.rx_tlast[1]  = 1'b1;
      ifa.clear        = 1'b1;
      step();
      snapshot();

      // randomized traffic, periodic triggers and back-pressure
      ifa.sample_period = 32'd37;
      for (int i = 0; i < 1500; i++) begin
         ifa.enable        = ($urandom_range(7) != 0);
         ifa.time_running  = ($urandom_range(7) != 0);
         ifa.tx_tvalid     = N'($urandom);
         ifa.tx_tready     = N'($urandom);
         ifa.tx_tlast      = N'($urandom) & N'($urandom);
         ifa.tx_tkeep      = (N*BB)'($urandom);
         ifa.rx_tvalid     = N'($urandom);
         ifa.rx_tlast      = N'($urandom) & N'($urandom);
         ifa.rx_tuser      = N'($urandom);
         ifa.rx_tkeep      = (N*BB)'($urandom);
         ifa.sample_req    = ($urandom_range(29) == 0);
         ifa.clear         = ($urandom_range(199) == 0);
         ifa.m_axis_tready = ($urandom_range(3) != 0);
         step();
      end
      ifa.sample_period = '0;
      ifa.enable = 1'b1; ifa.time_running = 1'b1; ifa.tx_tready = '1;
      drain();

      // reset with word 5 of a record pending, then a fresh record must carry seq 0
      ifa.sample_req = 1'b1;
      step();
      for (int i = 0; i < 5; i++) step();
      do_reset();
      snapshot();

      // periodic triggers against a stalled sink: one accepted, two dropped
      ifa.m_axis_tready = 1'b0;
      ifa.sample_period = 32'd100;
      for (int i = 0; i < 300; i++) step();
      ifa.sample_period = '0;
      chk("stall_ovf_a", ifa.overflow_count, 16'd2);
      chk("stall_ovf_b", ifb.overflow_count, 16'd2);
      drain();

      chk("a_records_drained", qa.size(), 0);
      chk("b_records_drained", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
